// File: rtl/lpc_record_fifo.sv
// Buffers captured LPC transactions and streams each one as a 9-byte record
// (10 bytes with a leading 0xA5 sync byte when LPC_REC_SYNC_EN is defined).
module lpc_record_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             lpc_clock,
  input  logic             lpc_reset,
  input  logic [3:0]       in_cyctype_dir,
  input  logic [3:0]       in_data_size,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             clr_overflow,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = CNT_W - 1;
`ifdef LPC_REC_SYNC_EN
  localparam int REC_BYTES = 10;
`else
  localparam int REC_BYTES = 9;
`endif
  localparam int REC_W = REC_BYTES * 8;
  localparam logic [3:0] LAST_IDX = 4'(REC_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic               prev_valid;
  logic               push, push_ok, pop;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [71:0]        mem [DEPTH];
  logic [71:0]        head;
  logic [REC_W-1:0]   load_rec;
  logic [REC_W-1:0]   rec_q;
  logic [3:0]         byte_idx;

  assign push       = in_valid & ~prev_valid;
  // Room is judged on the count at the start of the cycle; a concurrent pop does not help.
  assign push_ok    = push && (count_q < CNT_W'(DEPTH));
  assign fifo_count = count_q;
  assign head       = mem[rd_ptr];

`ifdef LPC_REC_SYNC_EN
  assign load_rec = {8'hA5, head};
`else
  assign load_rec = head;
`endif

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      prev_valid <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow   <= 1'b0;
    end else begin
      prev_valid <= in_valid;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (push_ok)
      mem[wr_ptr] <= {in_cyctype_dir, in_data_size, in_addr, in_data};
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q  <= IDLE;
      rec_q    <= '0;
      byte_idx <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        rec_q    <= load_rec;
        byte_idx <= '0;
      end else if (state_q == SEND && tx_ready) begin
        rec_q    <= rec_q << 8;
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_byte  = rec_q[REC_W-1 -: 8];
        if (tx_ready && byte_idx == LAST_IDX)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lpc_record_fifo.sv
// Directed bench for lpc_record_fifo: latency, backpressure, overflow, no-retrigger, reset mid-record.
module tb_lpc_record_fifo;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset;
  logic [3:0]  in_cyctype_dir;
  logic [3:0]  in_data_size;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        clr_overflow;
  logic        overflow;
  logic [3:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  lpc_record_fifo #(.DEPTH(8), .CNT_W(4)) dut (
    .lpc_clock      (lpc_clock),
    .lpc_reset      (lpc_reset),
    .in_cyctype_dir (in_cyctype_dir),
    .in_data_size   (in_data_size),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .tx_ready       (tx_ready),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid),
    .clr_overflow   (clr_overflow),
    .overflow       (overflow),
    .fifo_count     (fifo_count)
  );

  always #5 lpc_clock = ~lpc_clock;

  // Bytes accepted by the sink (valid & ready seen mid-cycle, taken at the next edge).
  always @(negedge lpc_clock)
    if (lpc_reset && tx_valid && tx_ready) rx_q.push_back(tx_byte);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge lpc_clock);
    #1;
  endtask

  task automatic add_rec(input logic [3:0] ct, input logic [3:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
`ifdef LPC_REC_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back({ct, sz});
    for (int b = 3; b >= 0; b--) exp_q.push_back(a[8*b +: 8]);
    for (int b = 3; b >= 0; b--) exp_q.push_back(d[8*b +: 8]);
  endtask

  // One-cycle in_valid pulse; clr is driven in the same cycle as the push.
  task automatic capture(input logic [3:0] ct, input logic [3:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input logic clr);
    tick();
    in_cyctype_dir = ct; in_data_size = sz; in_addr = a; in_data = d;
    in_valid = 1'b1; clr_overflow = clr;
    tick();
    in_valid = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    int mism;
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    mism = 0;
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) mism++;
    chk({tag, "_bad_bytes"}, mism, 0);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    lpc_reset = 1'b0; in_valid = 1'b0; tx_ready = 1'b0; clr_overflow = 1'b0;
    in_cyctype_dir = '0; in_data_size = '0; in_addr = '0; in_data = '0;

    // Reset state
    repeat (2) @(negedge lpc_clock);
    chk("rst_count", fifo_count, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_ovf", overflow, 0);
    tick();
    lpc_reset = 1'b1;
    repeat (3) tick();

    // Single record with cycle-accurate latency
    tx_ready = 1'b1;
    tick();
    in_cyctype_dir = 4'h2; in_data_size = 4'h1; in_addr = 32'h0000_0080; in_data = 32'h0000_00AB;
    in_valid = 1'b1;
    add_rec(4'h2, 4'h1, 32'h0000_0080, 32'h0000_00AB);
    @(negedge lpc_clock);
    chk("lat_count0", fifo_count, 0);
    tick();
    in_valid = 1'b0;
    @(negedge lpc_clock);
    chk("lat_count1", fifo_count, 1);
    chk("lat_valid1", tx_valid, 0);
    tick();
    @(negedge lpc_clock);
    chk("lat_valid2", tx_valid, 1);
    chk("lat_b0", tx_byte, 8'h21);
    chk("lat_count2", fifo_count, 0);
    repeat (15) tick();
    cmp_stream("single");
    chk("single_count", fifo_count, 0);

    // Memory read record (sync-byte variant adds A5 in front)
    capture(4'h0, 4'h4, 32'hFFFF_FFF0, 32'h1234_5678, 1'b0);
    add_rec(4'h0, 4'h4, 32'hFFFF_FFF0, 32'h1234_5678);
    repeat (15) tick();
    cmp_stream("memrd");

    // Backpressure: B0 must hold for the whole stall
    tx_ready = 1'b0;
    capture(4'h2, 4'h1, 32'h0000_0080, 32'h0000_00AB, 1'b0);
    add_rec(4'h2, 4'h1, 32'h0000_0080, 32'h0000_00AB);
    for (int i = 0; i < 10; i++) begin
      @(negedge lpc_clock);
      if (tx_valid) break;
    end
    chk("bp_valid_seen", tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_byte", tx_byte, 8'h21);
      chk("bp_hold_valid", tx_valid, 1);
      @(negedge lpc_clock);
    end
    @(posedge lpc_clock); #1;
    tx_ready = 1'b1;
    repeat (15) tick();
    cmp_stream("bp");

    // Overflow: record 0 sits stalled in the serializer, 1..8 fill the FIFO, 9 and 10 drop
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      capture(4'h3, 4'h4, 32'h1000_0000 + i, 32'hD000_0000 | i, 1'b0);
      add_rec(4'h3, 4'h4, 32'h1000_0000 + i, 32'hD000_0000 | i);
    end
    @(negedge lpc_clock);
    chk("ovf_full_count", fifo_count, 8);
    chk("ovf_not_yet", overflow, 0);
    capture(4'h3, 4'h4, 32'h1000_0009, 32'hD000_0009, 1'b0);
    @(negedge lpc_clock);
    chk("ovf_set", overflow, 1);
    chk("ovf_count_sat", fifo_count, 8);
    capture(4'h3, 4'h4, 32'h1000_000A, 32'hD000_000A, 1'b1);
    @(negedge lpc_clock);
    chk("ovf_set_wins", overflow, 1);
    tick();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    @(negedge lpc_clock);
    chk("ovf_cleared", overflow, 0);
    chk("ovf_count_kept", fifo_count, 8);
    @(posedge lpc_clock); #1;
    tx_ready = 1'b1;
    repeat (120) tick();
    cmp_stream("ovf_drain");
    chk("ovf_drain_count", fifo_count, 0);

    // in_valid held high: exactly one record
    tick();
    in_cyctype_dir = 4'h1; in_data_size = 4'h2; in_addr = 32'hCAFE_0001; in_data = 32'h5A5A_1234;
    in_valid = 1'b1;
    add_rec(4'h1, 4'h2, 32'hCAFE_0001, 32'h5A5A_1234);
    repeat (20) tick();
    in_valid = 1'b0;
    repeat (15) tick();
    cmp_stream("noretrig");
    chk("noretrig_count", fifo_count, 0);

    // Reset during B4 with two records queued
    tx_ready = 1'b0;
    capture(4'h2, 4'h1, 32'hAABB_CCDD, 32'h0000_0001, 1'b0);
    capture(4'h2, 4'h1, 32'hAABB_CCDE, 32'h0000_0002, 1'b0);
    capture(4'h2, 4'h1, 32'hAABB_CCDF, 32'h0000_0003, 1'b0);
    repeat (3) tick();
    chk("mid_queued", fifo_count, 2);
    tx_ready = 1'b1;
`ifdef LPC_REC_SYNC_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge lpc_clock); #1;
      if (rx_q.size() == 5) break;
    end
    chk("mid_reach", rx_q.size(), 5);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge lpc_clock); #1;
      if (rx_q.size() == 4) break;
    end
    chk("mid_reach", rx_q.size(), 4);
`endif
    @(posedge lpc_clock); #1;
    chk("mid_b4", tx_byte, 8'hDD);
    lpc_reset = 1'b0;
    in_valid  = 1'b1;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_byte", tx_byte, 0);
    rx_q.delete();
    repeat (2) tick();
    lpc_reset = 1'b1;
    repeat (20) tick();
    chk("mid_after_sent", rx_q.size(), 0);
    chk("mid_after_count", fifo_count, 0);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
